hex_line_parser: RTL
====================

HEX_LINE_PARSER -- requirements
Module: hex_line_parser

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning UART byte width; only 8 is legal.
REQ-002 SHALL have parameter DIGITS, default 8, meaning max hex digits per line; legal range 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_rx_data  input  DATA_BITS  ASCII byte read from the UART RX FIFO.
REQ-006 SHALL have port i_rx_valid  input  1  i_rx_data is valid.
REQ-007 SHALL have port o_rx_ready  output  1  parser accepts a byte this cycle.
REQ-008 SHALL have port o_word  output  4*DIGITS  parsed value, right-aligned and zero-extended.
REQ-009 SHALL have port o_word_valid  output  1  o_word holds a complete line's value.
REQ-010 SHALL have port i_word_ready  input  1  consumer (seg7 write path) takes o_word.
REQ-011 SHALL have port o_err  output  1  one-cycle pulse on line error.
REQ-012 SHALL have port o_err_cnt  output  8  saturating count of line errors.

Function
REQ-013 SHALL transfer a byte only when i_rx_valid && o_rx_ready in the same cycle.
REQ-014 SHALL transfer a word only when o_word_valid && i_word_ready in the same cycle.
REQ-015 SHALL implement three states: ACCUM, EMIT and DISCARD.
REQ-016 SHALL drive o_rx_ready=1 in ACCUM and DISCARD, and 0 in EMIT.
REQ-017 SHALL decode digits '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) to nibbles 0-15.
REQ-018 SHALL treat CR (0x0D) and LF (0x0A) as terminators.
REQ-019 SHALL, in ACCUM, on a digit with cnt<DIGITS, set acc <= {acc[4*DIGITS-5:0], nibble} and cnt <= cnt+1.
REQ-020 SHALL, in ACCUM, on a digit with cnt==DIGITS (overflow), pulse o_err, increment o_err_cnt and go to DISCARD.
REQ-021 SHALL, in ACCUM, on any non-digit non-terminator byte, pulse o_err, increment o_err_cnt and go to DISCARD.
REQ-022 SHALL, in ACCUM, on a terminator with cnt>0, load o_word <= acc and go to EMIT.
REQ-023 SHALL ignore a terminator in ACCUM with cnt==0 (no word, no error), so "\r\n" yields exactly one word.
REQ-024 SHALL assert o_word_valid exactly while in EMIT, holding o_word stable until the transfer.
REQ-025 SHALL, in EMIT, on transfer, clear acc and cnt and return to ACCUM on the next cycle.
REQ-026 SHALL, in DISCARD, consume and drop bytes, and on a terminator clear acc and cnt and go to ACCUM.
REQ-027 SHALL saturate o_err_cnt at 255.
REQ-028 SHALL hold o_err high for exactly the cycle following the offending byte transfer.
REQ-029 SHALL use a cnt width of $clog2(DIGITS+1) bits.
REQ-030 SHALL have a latency of 1 cycle from terminator transfer to o_word_valid=1, with no combinational path from i_rx_valid to o_word_valid.
REQ-031 SHALL allow o_rx_ready to depend only on state, and never on i_rx_valid.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, set state=ACCUM, acc=0, cnt=0, o_word=0, o_word_valid=0, o_err=0 and o_err_cnt=0.
REQ-033 SHALL give rst priority over any simultaneous byte or word transfer; a partial line or pending word is discarded.
REQ-034 SHALL drive o_rx_ready=1 on the first cycle after reset is deasserted.

Verification
REQ-035 SHALL cover: bytes "1aF3\r" with i_word_ready=1 -> o_word=0x00001AF3 with o_word_valid for 1 cycle, o_err_cnt=0.
REQ-036 SHALL cover: "123456789\n", then "5\r" (DIGITS=8) -> o_err pulse on the 9th digit, o_err_cnt=1, no word for line 1, then o_word=0x00000005.
REQ-037 SHALL cover: "\r\n\r\n" -> no o_word_valid and no o_err.
REQ-038 SHALL cover: "12G4\r", then "AB\n" -> o_err on 'G', remaining bytes dropped, then o_word=0x000000AB.
REQ-039 SHALL cover: "7\r" with i_word_ready=0 for 10 cycles -> o_word_valid=1 and o_word=0x7 stable, o_rx_ready=0 throughout, transfer on the cycle ready rises.
REQ-040 SHALL cover: "12", then rst for 1 cycle, then "3\r" -> o_word=0x00000003, o_err_cnt=0.

Source files
------------

// File: rtl/hex_line_parser.sv
// Collects ASCII hex digits from a UART byte stream and emits one word per
// CR/LF-terminated line; malformed or over-long lines are counted and dropped.
module hex_line_parser #(
    parameter int DATA_BITS = 8,
    parameter int DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [4*DIGITS-1:0]   o_word,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic                  o_err,
    output logic [7:0]            o_err_cnt
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {ACCUM, EMIT, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    o_word_q, o_word_d;
    logic            o_word_valid_q, o_word_valid_d;
    logic            o_err_q, o_err_d;
    logic [7:0]      o_err_cnt_q, o_err_cnt_d;

    logic            is_digit;
    logic            is_term;
    logic [3:0]      nibble;
    logic [W+3:0]    shifted;
    logic            rx_fire;
    logic            word_fire;

    always_comb begin
        is_digit = 1'b0;
        nibble   = 4'd0;
        is_term  = (i_rx_data == DATA_BITS'(8'h0D)) || (i_rx_data == DATA_BITS'(8'h0A));
        if (i_rx_data >= DATA_BITS'(8'h30) && i_rx_data <= DATA_BITS'(8'h39)) begin
            is_digit = 1'b1;
            nibble   = 4'(i_rx_data - DATA_BITS'(8'h30));
        end else if (i_rx_data >= DATA_BITS'(8'h41) && i_rx_data <= DATA_BITS'(8'h46)) begin
            is_digit = 1'b1;
            nibble   = 4'(i_rx_data - DATA_BITS'(8'h37));
        end else if (i_rx_data >= DATA_BITS'(8'h61) && i_rx_data <= DATA_BITS'(8'h66)) begin
            is_digit = 1'b1;
            nibble   = 4'(i_rx_data - DATA_BITS'(8'h57));
        end
    end

    // Widened shift so a single-digit configuration needs no special case.
    assign shifted   = {acc_q, nibble};
    assign rx_fire   = i_rx_valid && o_rx_ready;
    assign word_fire = o_word_valid_q && i_word_ready;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        o_word_d       = o_word_q;
        o_word_valid_d = o_word_valid_q;
        o_err_d        = 1'b0;
        o_err_cnt_d    = o_err_cnt_q;
        case (state_q)
            ACCUM: begin
                if (rx_fire) begin
                    if (is_digit && cnt_q != CW'(DIGITS)) begin
                        acc_d = shifted[W-1:0];
                        cnt_d = cnt_q + CW'(1);
                    end else if (is_term) begin
                        if (cnt_q != '0) begin
                            o_word_d       = acc_q;
                            o_word_valid_d = 1'b1;
                            state_d        = EMIT;
                        end
                    end else begin
                        o_err_d = 1'b1;
                        if (o_err_cnt_q != 8'hFF) o_err_cnt_d = o_err_cnt_q + 8'd1;
                        state_d = DISCARD;
                    end
                end
            end
            EMIT: begin
                if (word_fire) begin
                    acc_d          = '0;
                    cnt_d          = '0;
                    o_word_valid_d = 1'b0;
                    state_d        = ACCUM;
                end
            end
            DISCARD: begin
                if (rx_fire && is_term) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ACCUM;
            acc_q          <= '0;
            cnt_q          <= '0;
            o_word_q       <= '0;
            o_word_valid_q <= 1'b0;
            o_err_q        <= 1'b0;
            o_err_cnt_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            o_word_q       <= o_word_d;
            o_word_valid_q <= o_word_valid_d;
            o_err_q        <= o_err_d;
            o_err_cnt_q    <= o_err_cnt_d;
        end
    end

    assign o_rx_ready   = (state_q != EMIT);
    assign o_word       = o_word_q;
    assign o_word_valid = o_word_valid_q;
    assign o_err        = o_err_q;
    assign o_err_cnt    = o_err_cnt_q;
endmodule
